seven_segment_scan_capture: RTL and testbench

//   Receive-side counterpart of the seven-segment decoder. Monitors a multiplexed

---
 rtl/seven_segment_scan_capture_if.sv | 43 ++++
 rtl/seven_segment_scan_capture.sv | 216 +++++++++++++++++++++
 tb/tb_seven_segment_scan_capture.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_scan_capture_if.sv
// ---------------------------------------------------------------------------
// seven_segment_scan_capture_if
//
// Purpose:
//   Groups the multiplexed seven-segment display bus and the readback results
//   of the scan-capture monitor into one bundle.
//
// Signals:
//   seg_in       8         {dp,g,f,e,d,c,b,a}; 1 = segment lit
//   dig_sel      DIGITS    one-hot digit select; 1 = digit enabled
//   digits       4*DIGITS  captured hex values; digit i at [4i+3:4i]
//   dp           DIGITS    captured decimal point per digit
//   digit_valid  DIGITS    1 = last capture of that digit was a legal pattern
//   frame_done   1         1-cycle pulse once every digit has been captured
//   err          1         1-cycle pulse on illegal pattern or multi-hot select
//
// Modports:
//   master : display side, drives the bus and observes the results
//   slave  : the capture monitor
// ---------------------------------------------------------------------------
interface seven_segment_scan_capture_if #(
  parameter int DIGITS = 4
);

  logic [7:0]          seg_in;
  logic [DIGITS-1:0]   dig_sel;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   digit_valid;
  logic                frame_done;
  logic                err;

  modport master (
    output seg_in, dig_sel,
    input  digits, dp, digit_valid, frame_done, err
  );

  modport slave (
    input  seg_in, dig_sel,
    output digits, dp, digit_valid, frame_done, err
  );

endinterface

// File: rtl/seven_segment_scan_capture.sv
// ---------------------------------------------------------------------------
// seven_segment_scan_capture
//
// Purpose:
//   Watches a multiplexed seven-segment display bus, waits for each scan slot
//   to hold still for STABLE_CYCLES samples, then converts the lit pattern of
//   the selected digit back to its 4-bit hex value. Used as a readback monitor
//   next to a display driver or to sniff an external scanned display.
//
// Parameters:
//   DIGITS         number of multiplexed digits, 1..8
//   STABLE_CYCLES  identical consecutive samples needed before capture, 2..255
//
// Ports:
//   clk    input  system clock, rising edge
//   rst_n  input  asynchronous reset, active low
//   bus    slave modport of seven_segment_scan_capture_if
//            (seg_in, dig_sel in; digits, dp, digit_valid, frame_done, err out)
//
// Configuration:
//   SSD_CAPTURE_SYNC_EN  when defined, seg_in and dig_sel pass through 2-flop
//                        synchronisers (pin-to-capture = STABLE_CYCLES+2
//                        edges). When undefined the pins are sampled directly
//                        (STABLE_CYCLES edges); only safe for a bus generated
//                        in the clk domain.
// ---------------------------------------------------------------------------
module seven_segment_scan_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  seven_segment_scan_capture_if.slave   bus
);

  localparam int                SAMPLE_W  = DIGITS + 8;
  localparam logic [DIGITS-1:0] ALL_DIGITS = {DIGITS{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  logic [7:0]          w_seg;
  logic [DIGITS-1:0]   w_sel;
  logic [SAMPLE_W-1:0] w_sample;
  logic [SAMPLE_W-1:0] r_prevSample;
  logic [7:0]          r_count;
  logic                w_same;
  logic                w_reach;
  logic                w_selZero;
  logic                w_oneHot;
  logic [4:0]          w_decoded;
  logic                w_legal;
  logic [3:0]          w_value;
  logic [DIGITS-1:0]   w_capBits;

  state_t              r_state;
  logic [4*DIGITS-1:0] r_digits;
  logic [DIGITS-1:0]   r_dp;
  logic [DIGITS-1:0]   r_digitValid;
  logic [DIGITS-1:0]   r_mask;
  logic                r_frameDone;
  logic                r_err;

`ifdef SSD_CAPTURE_SYNC_EN
  logic [7:0]        r_segMeta;
  logic [7:0]        r_segSync;
  logic [DIGITS-1:0] r_selMeta;
  logic [DIGITS-1:0] r_selSync;

  // The display bus may come from another clock domain, so both the segment
  // lines and the digit selects are brought in through two flops before any
  // comparison or decoding looks at them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_segMeta <= '0;
      r_segSync <= '0;
      r_selMeta <= '0;
      r_selSync <= '0;
    end else begin
      r_segMeta <= bus.seg_in;
      r_segSync <= r_segMeta;
      r_selMeta <= bus.dig_sel;
      r_selSync <= r_selMeta;
    end
  end

  assign w_seg = r_segSync;
  assign w_sel = r_selSync;
`else
  assign w_seg = bus.seg_in;
  assign w_sel = bus.dig_sel;
`endif

  // Map a lit pattern back to its hex digit. Bit 4 of the result flags a
  // recognised pattern; anything outside the sixteen glyphs decodes to 0.
  function automatic logic [4:0] decodeSeg(input logic [6:0] pattern);
    logic [4:0] result;
    case (pattern)
      7'h3F:   result = {1'b1, 4'h0};
      7'h06:   result = {1'b1, 4'h1};
      7'h5B:   result = {1'b1, 4'h2};
      7'h4F:   result = {1'b1, 4'h3};
      7'h66:   result = {1'b1, 4'h4};
      7'h6D:   result = {1'b1, 4'h5};
      7'h7D:   result = {1'b1, 4'h6};
      7'h07:   result = {1'b1, 4'h7};
      7'h7F:   result = {1'b1, 4'h8};
      7'h6F:   result = {1'b1, 4'h9};
      7'h77:   result = {1'b1, 4'hA};
      7'h7C:   result = {1'b1, 4'hB};
      7'h39:   result = {1'b1, 4'hC};
      7'h5E:   result = {1'b1, 4'hD};
      7'h79:   result = {1'b1, 4'hE};
      7'h71:   result = {1'b1, 4'hF};
      default: result = 5'b0_0000;
    endcase
    return result;
  endfunction

  assign w_sample  = {w_sel, w_seg};
  assign w_same    = (w_sample == r_prevSample);
  // The capture edge is the one on which the count would step up to
  // STABLE_CYCLES, i.e. STABLE_CYCLES edges after the sample first appeared.
  assign w_reach   = w_same && (r_count == 8'(STABLE_CYCLES - 1));
  assign w_selZero = (w_sel == '0);
  assign w_oneHot  = !w_selZero && ((w_sel & (w_sel - DIGITS'(1))) == '0);
  assign w_decoded = decodeSeg(w_seg[6:0]);
  assign w_legal   = w_decoded[4];
  assign w_value   = w_decoded[3:0];
  assign w_capBits = (r_state == SETTLE && w_reach && w_oneHot) ? w_sel : '0;

  // Stability tracker: remembers the previous sample and counts how many
  // edges in a row it has stayed the same. Any change restarts the count, and
  // the count parks at STABLE_CYCLES so a long-held slot never wraps around.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prevSample <= '0;
      r_count      <= '0;
    end else begin
      r_prevSample <= w_sample;
      if (!w_same) begin
        r_count <= '0;
      end else if (r_count != 8'(STABLE_CYCLES)) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  // Scan FSM with all visible outputs registered here. IDLE rides out the
  // blanking gap, SETTLE waits for the slot to become stable and then
  // captures (or flags a multi-hot select), and HOLD ignores the rest of the
  // slot so each stable slot produces exactly one capture. The captured mask
  // tracks which digits have been seen; once full it raises frame_done and
  // restarts, keeping any capture from that same edge in the fresh mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_digits     <= '0;
      r_dp         <= '0;
      r_digitValid <= '0;
      r_mask       <= '0;
      r_frameDone  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err       <= 1'b0;
      r_frameDone <= (r_mask == ALL_DIGITS);
      r_mask      <= ((r_mask == ALL_DIGITS) ? '0 : r_mask) | w_capBits;

      case (r_state)
        IDLE: begin
          if (!w_selZero) begin
            r_state <= SETTLE;
          end
        end

        SETTLE: begin
          if (w_selZero) begin
            r_state <= IDLE;
          end else if (w_reach) begin
            r_state <= HOLD;
            if (w_oneHot) begin
              for (int i = 0; i < DIGITS; i++) begin
                if (w_sel[i]) begin
                  r_digits[4*i +: 4] <= w_legal ? w_value : 4'h0;
                  r_dp[i]            <= w_seg[7];
                  r_digitValid[i]    <= w_legal;
                end
              end
              r_err <= !w_legal;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        HOLD: begin
          if (!w_same) begin
            r_state <= w_selZero ? IDLE : SETTLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.digits      = r_digits;
  assign bus.dp          = r_dp;
  assign bus.digit_valid = r_digitValid;
  assign bus.frame_done  = r_frameDone;
  assign bus.err         = r_err;

endmodule

// File: tb/tb_seven_segment_scan_capture.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_scan_capture
//
// Purpose:
//   Drives scan slots onto the display bus and predicts, for every slot held
//   long enough, the output snapshot, err/frame_done pulses and the edge on
//   which they appear. Predictions are queued as stimulus is applied and
//   popped whenever the DUT outputs change or pulse.
// ---------------------------------------------------------------------------
module tb_seven_segment_scan_capture;

  localparam int DIGITS = 4;
  localparam int STABLE = 8;
`ifdef SSD_CAPTURE_SYNC_EN
  localparam int LAT = STABLE + 2;
`else
  localparam int LAT = STABLE;
`endif

  typedef struct {
    int          cyc;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  valid;
    logic        err;
    logic        frame;
  } evt_t;

  logic clk = 1'b0;
  logic rst_n;

  seven_segment_scan_capture_if #(.DIGITS(DIGITS)) bus ();

  seven_segment_scan_capture #(
    .DIGITS       (DIGITS),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [6:0] segTable [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  evt_t        evtQ[$];
  int          assertCount = 0;
  int          failCount   = 0;
  int          cycleCnt    = 0;
  int          frameCount  = 0;
  int          expFrames   = 0;
  logic [15:0] expDigits;
  logic [3:0]  expDp;
  logic [3:0]  expValid;
  logic [3:0]  expMask;
  logic [15:0] lastDigits;
  logic [3:0]  lastDp;
  logic [3:0]  lastValid;

  // Free-running clock plus an edge counter used to timestamp events.
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               tag, observed, expected, cycleCnt);
    end
  endtask

  // Drives one scan slot for n cycles and, if it is held long enough to be
  // captured, queues the predicted outcome stamped with its capture edge.
  task automatic applyStimulus(input logic [3:0] sel, input logic [7:0] seg, input int n);
    evt_t ev;
    logic legal;
    logic [3:0] val;
    int   capEdge;
    bus.dig_sel = sel;
    bus.seg_in  = seg;
    capEdge = cycleCnt + 1 + LAT;
    if (n >= STABLE + 1 && sel != 4'b0000) begin
      if ($onehot(sel)) begin
        legal = 1'b0;
        val   = 4'h0;
        for (int k = 0; k < 16; k++) begin
          if (segTable[k] == seg[6:0]) begin
            legal = 1'b1;
            val   = 4'(k);
          end
        end
        for (int i = 0; i < DIGITS; i++) begin
          if (sel[i]) begin
            expDigits[4*i +: 4] = legal ? val : 4'h0;
            expDp[i]            = seg[7];
            expValid[i]         = legal;
          end
        end
        expMask = expMask | sel;
        ev.cyc = capEdge; ev.digits = expDigits; ev.dp = expDp; ev.valid = expValid;
        ev.err = !legal;  ev.frame = 1'b0;
        evtQ.push_back(ev);
        if (expMask == 4'hF) begin
          ev.cyc = capEdge + 1; ev.err = 1'b0; ev.frame = 1'b1;
          evtQ.push_back(ev);
          expMask = 4'h0;
          expFrames++;
        end
      end else begin
        ev.cyc = capEdge; ev.digits = expDigits; ev.dp = expDp; ev.valid = expValid;
        ev.err = 1'b1;    ev.frame = 1'b0;
        evtQ.push_back(ev);
      end
    end
    repeat (n) @(negedge clk);
  endtask

  // Output monitor: any change of the captured state, or an err/frame_done
  // pulse, is one DUT event and must match the oldest queued prediction.
  always @(negedge clk) begin : monitor
    evt_t e;
    if (!rst_n) begin
      lastDigits = '0;
      lastDp     = '0;
      lastValid  = '0;
    end else begin
      if (bus.frame_done) frameCount++;
      if (bus.digits != lastDigits || bus.dp != lastDp || bus.digit_valid != lastValid ||
          bus.err || bus.frame_done) begin
        if (evtQ.size() == 0) begin
          checkOutput("queue_underflow", evtQ.size(), 1);
        end else begin
          e = evtQ.pop_front();
          checkOutput("event_cycle", cycleCnt, e.cyc);
          checkOutput("digits", bus.digits, e.digits);
          checkOutput("dp", bus.dp, e.dp);
          checkOutput("digit_valid", bus.digit_valid, e.valid);
          checkOutput("err", bus.err, e.err);
          checkOutput("frame_done", bus.frame_done, e.frame);
        end
      end
      lastDigits = bus.digits;
      lastDp     = bus.dp;
      lastValid  = bus.digit_valid;
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_digits"}, bus.digits, 0);
    checkOutput({tag, "_dp"}, bus.dp, 0);
    checkOutput({tag, "_valid"}, bus.digit_valid, 0);
    checkOutput({tag, "_frame"}, bus.frame_done, 0);
    checkOutput({tag, "_err"}, bus.err, 0);
  endtask

  // Main sequence: reset, single capture, full frame, illegal pattern,
  // multi-hot select, glitch rejection, reset mid-settle, then drain.
  initial begin
    rst_n       = 1'b0;
    bus.dig_sel = '0;
    bus.seg_in  = '0;
    expDigits   = '0;
    expDp       = '0;
    expValid    = '0;
    expMask     = '0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single digit capture");
    applyStimulus(4'b0001, 8'h06, 12);
    applyStimulus(4'b0000, 8'h00, 4);

    $display("[TB] full frame scan");
    applyStimulus(4'b0001, 8'h3F, 10);
    applyStimulus(4'b0010, 8'h5B, 10);
    applyStimulus(4'b0100, 8'hF9, 10);
    applyStimulus(4'b1000, 8'h71, 10);
    applyStimulus(4'b0000, 8'h00, 4);

    $display("[TB] illegal pattern");
    applyStimulus(4'b0010, 8'h2A, 12);
    applyStimulus(4'b0000, 8'h00, 4);

    $display("[TB] multi-hot select");
    applyStimulus(4'b0011, 8'h06, 12);
    applyStimulus(4'b0000, 8'h00, 4);

    $display("[TB] glitch rejection");
    applyStimulus(4'b0001, 8'h6D, 5);
    applyStimulus(4'b0001, 8'h7F, 12);
    applyStimulus(4'b0000, 8'h00, 4);

    $display("[TB] reset mid-settle");
    applyStimulus(4'b0001, 8'h66, 4 + (LAT - STABLE));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("midreset");
    expDigits = '0;
    expDp     = '0;
    expValid  = '0;
    expMask   = '0;
    @(negedge clk);
    bus.dig_sel = '0;
    bus.seg_in  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b0001, 8'h4F, 12);
    applyStimulus(4'b0000, 8'h00, 4);

    for (int i = 0; i < 40 && evtQ.size() != 0; i++) @(negedge clk);
    checkOutput("queue_empty", evtQ.size(), 0);
    checkOutput("frame_count", frameCount, expFrames);
    checkOutput("final_digits", bus.digits, expDigits);
    checkOutput("final_valid", bus.digit_valid, expValid);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
